// File: rtl/io_pkg.sv
// Shared constants and helpers for the board input conditioner.
package io_pkg;

  localparam int unsigned IO_BUS_W         = 32;
  localparam int unsigned IO_SW_W          = 18;
  localparam int unsigned IO_KEY_W         = 4;
  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

  // $clog2 clamped to at least one bit so a 1-cycle debounce still has a legal counter
  function automatic int unsigned clog2_min1(input int unsigned val);
    return (val < 2) ? 1 : $clog2(val);
  endfunction

endpackage

// File: rtl/io_input_conditioner_if.sv
// Raw pin inputs and conditioned outputs of the input conditioner.
interface io_input_conditioner_if
  import io_pkg::*;
#(
  parameter int unsigned N_SW  = IO_SW_W,
  parameter int unsigned N_KEY = IO_KEY_W
);

  logic [N_SW-1:0]     sw_raw_i;
  logic [N_KEY-1:0]    key_raw_i;
  logic [IO_BUS_W-1:0] io_sw_o;
  logic [IO_BUS_W-1:0] io_keys_o;
  logic [N_KEY-1:0]    key_press_o;

  modport master (
    output sw_raw_i, key_raw_i,
    input  io_sw_o, io_keys_o, key_press_o
  );

  modport slave (
    input  sw_raw_i, key_raw_i,
    output io_sw_o, io_keys_o, key_press_o
  );

endinterface

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser, consecutive-sample debounce, stable flop.
// Counter present only when IO_DEBOUNCE_EN is defined; otherwise the synced sample passes straight through.
module debounce_bit
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic        RST_VAL         = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw,
  output logic stable
);

  logic s1;
  logic s2;
  logic s2n;

  // Sync flops idle at the pin's inactive level so reset looks like "not asserted"
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // XOR with the inactive level normalises to 1 = asserted
  assign s2n = s2 ^ RST_VAL;

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned   CW      = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (s2n == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= s2n;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = (DEBOUNCE_CYCLES == 0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable <= 1'b0;
    end else begin
      stable <= s2n;
    end
  end
`endif

endmodule

// File: rtl/io_input_conditioner.sv
// Synchronises and debounces board switches and keys; keys normalised to 1 = pressed with a press pulse.
// Debounce counters are built only when IO_DEBOUNCE_EN is defined.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int unsigned N_SW            = IO_SW_W,
  parameter int unsigned N_KEY           = IO_KEY_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  io_input_conditioner_if.slave  bus
);

  logic [N_SW-1:0]  sw_stable;
  logic [N_KEY-1:0] key_stable;
  logic [N_KEY-1:0] key_stable_d;

  for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_VAL         (1'b0)
    ) u_db (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw    (bus.sw_raw_i[gi]),
      .stable (sw_stable[gi])
    );
  end

  // Key inversion: the inactive pin level is both the sync reset value and the normalising XOR
  for (genvar gk = 0; gk < N_KEY; gk++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_VAL         (KEY_ACTIVE_LOW)
    ) u_db (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw    (bus.key_raw_i[gk]),
      .stable (key_stable[gk])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_stable_d <= '0;
    end else begin
      key_stable_d <= key_stable;
    end
  end

  assign bus.io_sw_o     = IO_BUS_W'(sw_stable);
  assign bus.io_keys_o   = IO_BUS_W'(key_stable);
  assign bus.key_press_o = key_stable & ~key_stable_d;

endmodule
